// File: rtl/overflow_interval_table_if.sv
// Bundle of write, invalidate, lookup and status signals for the overflow interval table.
// master = checker/LSU side driving requests, slave = the table itself.
interface overflow_interval_table_if #(
    parameter int DEPTH = 32,
    parameter int AW    = 32
);
    localparam int IDX_W = $clog2(DEPTH);

    logic             flush_i;
    logic             wr_valid_i;
    logic             wr_ready_o;
    logic [AW-1:0]    wr_first_i;
    logic [AW-1:0]    wr_last_i;
    logic             wr_err_o;
    logic             evict_o;
    logic             inv_valid_i;
    logic [AW-1:0]    inv_addr_i;
    logic             lkp_valid_i;
    logic [AW-1:0]    lkp_addr_i;
    logic             lkp_rsp_valid_o;
    logic             lkp_hit_o;
    logic             lkp_first_o;
    logic [IDX_W-1:0] lkp_idx_o;
    logic [IDX_W:0]   count_o;
    logic             full_o;

    modport master (
        output flush_i, wr_valid_i, wr_first_i, wr_last_i,
               inv_valid_i, inv_addr_i, lkp_valid_i, lkp_addr_i,
        input  wr_ready_o, wr_err_o, evict_o, lkp_rsp_valid_o,
               lkp_hit_o, lkp_first_o, lkp_idx_o, count_o, full_o
    );

    modport slave (
        input  flush_i, wr_valid_i, wr_first_i, wr_last_i,
               inv_valid_i, inv_addr_i, lkp_valid_i, lkp_addr_i,
        output wr_ready_o, wr_err_o, evict_o, lkp_rsp_valid_o,
               lkp_hit_o, lkp_first_o, lkp_idx_o, count_o, full_o
    );
endinterface

// File: rtl/overflow_interval_table.sv
// Store of [first,last] overflow intervals with valid bits, fill-holes-then-evict-oldest
// replacement, invalidate-by-address, flush, and a registered single-cycle lookup.
module overflow_interval_table #(
    parameter int DEPTH = 32,
    parameter int AW    = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    overflow_interval_table_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]    first_q [DEPTH];
    logic [AW-1:0]    last_q  [DEPTH];
    logic [IDX_W-1:0] evict_ptr_q, evict_ptr_d;

    logic             wr_err_q, evict_q;
    logic             rsp_valid_q, hit_q, first_hit_q;
    logic [IDX_W-1:0] idx_q;

    logic [DEPTH-1:0] hit_vec, first_vec, inv_vec;
    logic [IDX_W-1:0] free_idx, hit_idx, target_idx;
    logic [IDX_W:0]   count;
    logic             full, wr_acc, wr_bad, wr_ok, inv_act;

    // Per-entry comparators; all use the state registered at the start of the cycle.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign hit_vec[gi]   = valid_q[gi] && (first_q[gi] <= bus.lkp_addr_i)
                                           && (bus.lkp_addr_i <= last_q[gi]);
        assign first_vec[gi] = valid_q[gi] && (first_q[gi] == bus.lkp_addr_i);
        assign inv_vec[gi]   = valid_q[gi] && (first_q[gi] <= bus.inv_addr_i)
                                           && (bus.inv_addr_i <= last_q[gi]);
    end

    always_comb begin
        free_idx = '0;
        hit_idx  = '0;
        count    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
            if (hit_vec[i])  hit_idx  = IDX_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            count = count + (IDX_W + 1)'(valid_q[i]);
        end
    end

    assign full       = (count == (IDX_W + 1)'(DEPTH));
    assign wr_acc     = bus.wr_valid_i & ~bus.flush_i;
    assign wr_bad     = bus.wr_first_i > bus.wr_last_i;
    assign wr_ok      = wr_acc & ~wr_bad;
    assign inv_act    = bus.inv_valid_i & ~bus.flush_i;
    assign target_idx = full ? evict_ptr_q : free_idx;

    // A write into a slot that is also being invalidated wins.
    always_comb begin
        valid_d     = valid_q;
        evict_ptr_d = evict_ptr_q;
        if (bus.flush_i) begin
            valid_d     = '0;
            evict_ptr_d = '0;
        end else begin
            if (inv_act) valid_d = valid_q & ~inv_vec;
            if (wr_ok) begin
                valid_d[target_idx] = 1'b1;
                if (full) evict_ptr_d = evict_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            evict_ptr_q <= '0;
            wr_err_q    <= 1'b0;
            evict_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                first_q[i] <= '0;
                last_q[i]  <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            evict_ptr_q <= evict_ptr_d;
            wr_err_q    <= wr_acc & wr_bad;
            evict_q     <= wr_ok & full;
            if (wr_ok) begin
                first_q[target_idx] <= bus.wr_first_i;
                last_q[target_idx]  <= bus.wr_last_i;
            end
        end
    end

    // Response registers hold their last value between lookups.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            first_hit_q <= 1'b0;
            idx_q       <= '0;
        end else begin
            rsp_valid_q <= bus.lkp_valid_i;
            if (bus.lkp_valid_i) begin
                hit_q       <= |hit_vec;
                first_hit_q <= |first_vec;
                idx_q       <= hit_idx;
            end
        end
    end

    assign bus.wr_ready_o      = ~bus.flush_i & ~rst_i;
    assign bus.wr_err_o        = wr_err_q;
    assign bus.evict_o         = evict_q;
    assign bus.lkp_rsp_valid_o = rsp_valid_q;
    assign bus.lkp_hit_o       = hit_q;
    assign bus.lkp_first_o     = first_hit_q;
    assign bus.lkp_idx_o       = idx_q;
    assign bus.count_o         = count;
    assign bus.full_o          = full;
endmodule

// File: tb/tb_overflow_interval_table.sv
// Self-checking bench: directed scenarios plus random traffic against an array-based reference model.
module tb_overflow_interval_table;
    localparam int DEPTH = 32;
    localparam int AW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    overflow_interval_table_if #(.DEPTH(DEPTH), .AW(AW)) bus ();
    overflow_interval_table #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: plain list of entries, replacement pointer and expected outputs.
    bit          m_valid [DEPTH];
    logic [31:0] m_first [DEPTH];
    logic [31:0] m_last  [DEPTH];
    int          m_ptr;
    bit          e_err, e_evict, e_rsp, e_hit, e_first;
    int          e_idx, e_count;

    function automatic int m_popcount();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += m_valid[i];
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0; m_first[i] = 0; m_last[i] = 0;
        end
        m_ptr = 0; e_err = 0; e_evict = 0; e_rsp = 0; e_hit = 0; e_first = 0;
        e_idx = 0; e_count = 0;
    endtask

    task automatic idle_inputs();
        bus.flush_i = 0; bus.wr_valid_i = 0; bus.wr_first_i = 0; bus.wr_last_i = 0;
        bus.inv_valid_i = 0; bus.inv_addr_i = 0; bus.lkp_valid_i = 0; bus.lkp_addr_i = 0;
    endtask

    // Advance one clock; inputs are stable across the edge, so the model reads them afterwards.
    task automatic cycle();
        int  target;
        bit  was_full;
        logic [31:0] la, ia, wf, wl;
        @(posedge clk);
        #1;
        la = bus.lkp_addr_i; ia = bus.inv_addr_i; wf = bus.wr_first_i; wl = bus.wr_last_i;
        was_full = (m_popcount() == DEPTH);
        e_rsp = bus.lkp_valid_i;
        if (bus.lkp_valid_i) begin
            e_hit = 0; e_first = 0; e_idx = 0;
            for (int i = 0; i < DEPTH; i++) begin
                if (m_valid[i] && m_first[i] <= la && la <= m_last[i]) begin
                    if (!e_hit) e_idx = i;
                    e_hit = 1;
                    if (la == m_first[i]) e_first = 1;
                end
            end
        end
        e_err = 0; e_evict = 0;
        if (bus.flush_i) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
            m_ptr = 0;
        end else begin
            target = -1;
            if (bus.wr_valid_i && wf > wl) e_err = 1;
            if (bus.wr_valid_i && wf <= wl) begin
                if (was_full) begin
                    target = m_ptr; m_ptr = (m_ptr + 1) % DEPTH; e_evict = 1;
                end else begin
                    for (int i = DEPTH - 1; i >= 0; i--) if (!m_valid[i]) target = i;
                end
            end
            if (bus.inv_valid_i)
                for (int i = 0; i < DEPTH; i++)
                    if (m_first[i] <= ia && ia <= m_last[i]) m_valid[i] = 0;
            if (target >= 0) begin
                m_valid[target] = 1; m_first[target] = wf; m_last[target] = wl;
            end
        end
        e_count = m_popcount();
        $display("t=%0t txn fl=%0b wr=%0b[%h,%h] inv=%0b@%h lkp=%0b@%h -> rsp=%0b hit=%0b first=%0b idx=%0d cnt=%0d",
                 $time, bus.flush_i, bus.wr_valid_i, wf, wl, bus.inv_valid_i, ia,
                 bus.lkp_valid_i, la, bus.lkp_rsp_valid_o, bus.lkp_hit_o, bus.lkp_first_o,
                 bus.lkp_idx_o, bus.count_o);
    endtask

    task automatic drive(input bit fl, input bit wv, input logic [31:0] wf, input logic [31:0] wl,
                         input bit iv, input logic [31:0] ia, input bit lv, input logic [31:0] la);
        bus.flush_i = fl; bus.wr_valid_i = wv; bus.wr_first_i = wf; bus.wr_last_i = wl;
        bus.inv_valid_i = iv; bus.inv_addr_i = ia; bus.lkp_valid_i = lv; bus.lkp_addr_i = la;
        cycle();
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic fill_table(input int hole_a, input logic [31:0] fa, input logic [31:0] la_,
                              input int hole_b, input logic [31:0] fb, input logic [31:0] lb);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == hole_a)      drive(0, 1, fa, la_, 0, 0, 0, 0);
            else if (i == hole_b) drive(0, 1, fb, lb, 0, 0, 0, 0);
            else drive(0, 1, 32'h1000 + i * 32'h100, 32'h10FF + i * 32'h100, 0, 0, 0, 0);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.count_o !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count_o); end
        checks++; if (bus.full_o !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", bus.full_o); end
        checks++; if (bus.lkp_rsp_valid_o !== 1'b0 || bus.lkp_hit_o !== 1'b0 || bus.lkp_idx_o !== 5'd0)
            begin failures++; $display("FAIL reset_lkp got rsp=%0b hit=%0b idx=%0d exp=0,0,0", bus.lkp_rsp_valid_o, bus.lkp_hit_o, bus.lkp_idx_o); end
        checks++; if (bus.wr_err_o !== 1'b0 || bus.evict_o !== 1'b0)
            begin failures++; $display("FAIL reset_pulses got err=%0b ev=%0b exp=0,0", bus.wr_err_o, bus.evict_o); end
        checks++; if (bus.wr_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", bus.wr_ready_o); end
    endtask

    task automatic test_basic();
        drive(0, 1, 32'h100, 32'h1FF, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h100);
        checks++; if ({bus.lkp_rsp_valid_o, bus.lkp_hit_o, bus.lkp_first_o} !== 3'b111 || bus.lkp_idx_o !== 5'd0)
            begin failures++; $display("FAIL basic_hit got rsp/hit/first=%b idx=%0d exp=111 idx=0", {bus.lkp_rsp_valid_o, bus.lkp_hit_o, bus.lkp_first_o}, bus.lkp_idx_o); end
        drive(0, 0, 0, 0, 0, 0, 1, 32'h200);
        checks++; if (bus.lkp_hit_o !== 1'b0 || bus.lkp_rsp_valid_o !== 1'b1)
            begin failures++; $display("FAIL basic_miss got hit=%0b rsp=%0b exp=0,1", bus.lkp_hit_o, bus.lkp_rsp_valid_o); end
        checks++; if (bus.count_o !== 6'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", bus.count_o); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.lkp_rsp_valid_o !== 1'b0 || bus.lkp_hit_o !== 1'b0)
            begin failures++; $display("FAIL basic_hold got rsp=%0b hit=%0b exp=0,0", bus.lkp_rsp_valid_o, bus.lkp_hit_o); end
    endtask

    task automatic test_evict();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        fill_table(-1, 0, 0, -1, 0, 0);
        checks++; if (bus.full_o !== 1'b1 || bus.evict_o !== 1'b0)
            begin failures++; $display("FAIL evict_filled got full=%0b ev=%0b exp=1,0", bus.full_o, bus.evict_o); end
        drive(0, 1, 32'h9000, 32'h9010, 0, 0, 0, 0);
        checks++; if (bus.evict_o !== 1'b1 || bus.count_o !== 6'd32)
            begin failures++; $display("FAIL evict_33 got ev=%0b cnt=%0d exp=1,32", bus.evict_o, bus.count_o); end
        drive(0, 0, 0, 0, 0, 0, 1, 32'h9000);
        checks++; if (bus.lkp_hit_o !== 1'b1 || bus.lkp_idx_o !== 5'd0 || bus.evict_o !== 1'b0)
            begin failures++; $display("FAIL evict_slot0 got hit=%0b idx=%0d ev=%0b exp=1,0,0", bus.lkp_hit_o, bus.lkp_idx_o, bus.evict_o); end
        drive(0, 1, 32'hA000, 32'hA010, 0, 0, 1, 32'h1000);
        checks++; if (bus.lkp_hit_o !== 1'b0 || bus.evict_o !== 1'b1)
            begin failures++; $display("FAIL evict_old_gone got hit=%0b ev=%0b exp=0,1", bus.lkp_hit_o, bus.evict_o); end
        drive(0, 0, 0, 0, 0, 0, 1, 32'hA005);
        checks++; if (bus.lkp_hit_o !== 1'b1 || bus.lkp_idx_o !== 5'd1 || bus.lkp_first_o !== 1'b0)
            begin failures++; $display("FAIL evict_slot1 got hit=%0b idx=%0d first=%0b exp=1,1,0", bus.lkp_hit_o, bus.lkp_idx_o, bus.lkp_first_o); end
    endtask

    task automatic test_invalidate();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        fill_table(3, 32'h100, 32'h1FF, 7, 32'h105, 32'h105);
        drive(0, 0, 0, 0, 1, 32'h105, 0, 0);
        checks++; if (bus.count_o !== 6'd30 || bus.full_o !== 1'b0)
            begin failures++; $display("FAIL inv_count got cnt=%0d full=%0b exp=30,0", bus.count_o, bus.full_o); end
        drive(0, 1, 32'h7000, 32'h70FF, 0, 0, 0, 0);
        checks++; if (bus.evict_o !== 1'b0 || bus.count_o !== 6'd31)
            begin failures++; $display("FAIL inv_refill got ev=%0b cnt=%0d exp=0,31", bus.evict_o, bus.count_o); end
        drive(0, 0, 0, 0, 0, 0, 1, 32'h7000);
        checks++; if (bus.lkp_hit_o !== 1'b1 || bus.lkp_idx_o !== 5'd3)
            begin failures++; $display("FAIL inv_hole got hit=%0b idx=%0d exp=1,3", bus.lkp_hit_o, bus.lkp_idx_o); end
    endtask

    task automatic test_error();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h50, 32'h40, 0, 0, 0, 0);
        checks++; if (bus.wr_err_o !== 1'b1 || bus.count_o !== 6'd0)
            begin failures++; $display("FAIL err_pulse got err=%0b cnt=%0d exp=1,0", bus.wr_err_o, bus.count_o); end
        drive(0, 1, 32'h40, 32'h40, 0, 0, 0, 0);
        checks++; if (bus.wr_err_o !== 1'b0 || bus.count_o !== 6'd1)
            begin failures++; $display("FAIL err_single got err=%0b cnt=%0d exp=0,1", bus.wr_err_o, bus.count_o); end
        drive(0, 1, 32'hFFFF_FF00, 32'hFFFF_FFFF, 0, 0, 1, 32'h40);
        checks++; if (bus.lkp_hit_o !== 1'b1 || bus.lkp_first_o !== 1'b1)
            begin failures++; $display("FAIL err_lkp40 got hit=%0b first=%0b exp=1,1", bus.lkp_hit_o, bus.lkp_first_o); end
        drive(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        checks++; if (bus.lkp_hit_o !== 1'b1 || bus.lkp_idx_o !== 5'd1)
            begin failures++; $display("FAIL top_addr got hit=%0b idx=%0d exp=1,1", bus.lkp_hit_o, bus.lkp_idx_o); end
        drive(0, 0, 0, 0, 0, 0, 1, 32'h0);
        checks++; if (bus.lkp_hit_o !== 1'b0)
            begin failures++; $display("FAIL no_wrap got hit=%0b exp=0", bus.lkp_hit_o); end
    endtask

    task automatic test_flush();
        bus.flush_i = 1; bus.wr_valid_i = 1; bus.wr_first_i = 32'h800; bus.wr_last_i = 32'h900;
        #1;
        checks++; if (bus.wr_ready_o !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", bus.wr_ready_o); end
        cycle();
        idle_inputs();
        checks++; if (bus.count_o !== 6'd0 || bus.wr_err_o !== 1'b0 || bus.evict_o !== 1'b0)
            begin failures++; $display("FAIL flush_clear got cnt=%0d err=%0b ev=%0b exp=0,0,0", bus.count_o, bus.wr_err_o, bus.evict_o); end
        drive(0, 1, 32'h800, 32'h900, 1, 32'h850, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h850);
        checks++; if (bus.lkp_hit_o !== 1'b1 || bus.count_o !== 6'd1)
            begin failures++; $display("FAIL wr_inv_same got hit=%0b cnt=%0d exp=1,1", bus.lkp_hit_o, bus.count_o); end
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 32'h3000 + k * 32'h20, 32'h300F + k * 32'h20, 0, 0, 1, 32'h3000 + k * 32'h20);
            checks++; if (bus.lkp_rsp_valid_o !== 1'b1 || bus.lkp_hit_o !== 1'b0)
                begin failures++; $display("FAIL b2b_same_cycle k=%0d got rsp=%0b hit=%0b exp=1,0", k, bus.lkp_rsp_valid_o, bus.lkp_hit_o); end
            drive(0, 1, 32'h5000 + k, 32'h5000 + k, 0, 0, 1, 32'h3000 + k * 32'h20);
            checks++; if (bus.lkp_rsp_valid_o !== 1'b1 || bus.lkp_hit_o !== 1'b1 || bus.lkp_idx_o !== 5'(2 * k))
                begin failures++; $display("FAIL b2b_next_cycle k=%0d got rsp=%0b hit=%0b idx=%0d exp=1,1,%0d", k, bus.lkp_rsp_valid_o, bus.lkp_hit_o, bus.lkp_idx_o, 2 * k); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int n = 0; n < 400; n++) begin
            a = $urandom_range(0, 32'h3FF);
            b = ($urandom_range(0, 9) == 0) ? a - $urandom_range(1, 8) : a + $urandom_range(0, 64);
            drive(($urandom_range(0, 60) == 0), ($urandom_range(0, 2) != 0), a, b,
                  ($urandom_range(0, 5) == 0), $urandom_range(0, 32'h400),
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 32'h440));
            checks++;
            if (bus.wr_err_o !== e_err || bus.evict_o !== e_evict || bus.lkp_rsp_valid_o !== e_rsp ||
                bus.lkp_hit_o !== e_hit || bus.lkp_first_o !== e_first || bus.lkp_idx_o !== 5'(e_idx) ||
                bus.count_o !== 6'(e_count) || bus.full_o !== (e_count == DEPTH))
                begin failures++;
                $display("FAIL random n=%0d got err=%0b ev=%0b rsp=%0b hit=%0b first=%0b idx=%0d cnt=%0d exp err=%0b ev=%0b rsp=%0b hit=%0b first=%0b idx=%0d cnt=%0d",
                         n, bus.wr_err_o, bus.evict_o, bus.lkp_rsp_valid_o, bus.lkp_hit_o, bus.lkp_first_o, bus.lkp_idx_o, bus.count_o,
                         e_err, e_evict, e_rsp, e_hit, e_first, e_idx, e_count); end
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h20, 32'h30, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h25);
        checks++; if (bus.lkp_rsp_valid_o !== 1'b1 || bus.lkp_hit_o !== 1'b1)
            begin failures++; $display("FAIL pre_rst got rsp=%0b hit=%0b exp=1,1", bus.lkp_rsp_valid_o, bus.lkp_hit_o); end
        bus.lkp_valid_i = 1; bus.lkp_addr_i = 32'h25;
        #2 rst = 1;
        #1;
        checks++; if (bus.lkp_rsp_valid_o !== 1'b0 || bus.lkp_hit_o !== 1'b0 || bus.count_o !== 6'd0 ||
                      bus.wr_ready_o !== 1'b0 || bus.full_o !== 1'b0)
            begin failures++; $display("FAIL async_rst got rsp=%0b hit=%0b cnt=%0d rdy=%0b exp=0,0,0,0", bus.lkp_rsp_valid_o, bus.lkp_hit_o, bus.count_o, bus.wr_ready_o); end
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h25);
        checks++; if (bus.lkp_hit_o !== 1'b0 || bus.count_o !== 6'd0)
            begin failures++; $display("FAIL post_rst got hit=%0b cnt=%0d exp=0,0", bus.lkp_hit_o, bus.count_o); end
    endtask

    initial begin
        idle_inputs();
        model_clear();
        test_reset();
        test_basic();
        test_evict();
        test_invalidate();
        test_error();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
